// File: rtl/dct2_transpose_buf.sv
// Single-buffered transpose store between the row and column passes of a 2-D DCT.
// A block of S rows is collected in FILL, then S columns are emitted in DRAIN.
module dct2_transpose_buf #(
  parameter int DW    = 16,
  parameter int LANES = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] in_row,
  input  logic [1:0]          in_n,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*DW-1:0] out_col,
  output logic [1:0]          out_n
);

  localparam int CW = $clog2(LANES);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   r_q, r_d;
  logic [CW-1:0]   c_q, c_d;
  logic [1:0]      n_q, n_d;
  logic [DW-1:0]   mem_q [LANES][LANES];

  logic            row_xfer, col_xfer;
  logic [1:0]      n_wr;
  logic [CW:0]     s_wr, s_rd;
  logic [LANES-1:0] wr_mask, rd_mask;
  logic            last_row, last_col;

  assign in_ready  = !rst && (state_q == FILL);
  assign out_valid = !rst && (state_q == DRAIN);
  assign out_n     = rst ? 2'b00 : n_q;
  assign row_xfer  = in_valid && in_ready;
  assign col_xfer  = out_valid && out_ready;

  // Row 0 carries the size code for the whole block; later rows reuse n_q.
  assign n_wr     = (r_q == '0) ? in_n : n_q;
  assign s_wr     = (CW+1)'(4) << n_wr;
  assign s_rd     = (CW+1)'(4) << n_q;
  assign last_row = ({1'b0, r_q} == s_wr - (CW+1)'(1));
  assign last_col = ({1'b0, c_q} == s_rd - (CW+1)'(1));

  always_comb begin
    wr_mask = '0;
    rd_mask = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      wr_mask[i] = ((CW+1)'(i) < s_wr);
      rd_mask[i] = ((CW+1)'(i) < s_rd);
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    n_d     = n_q;
    if (row_xfer) begin
      if (r_q == '0) n_d = in_n;
      if (last_row) begin
        r_d     = '0;
        state_d = DRAIN;
      end else begin
        r_d = r_q + CW'(1);
      end
    end
    if (col_xfer) begin
      if (last_col) begin
        c_d     = '0;
        state_d = FILL;
      end else begin
        c_d = c_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      r_q     <= '0;
      c_q     <= '0;
      n_q     <= 2'b00;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      n_q     <= n_d;
    end
  end

  // Storage is deliberately not reset; reads are masked to the current block size.
  always_ff @(posedge clk) begin
    if (row_xfer) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (wr_mask[i]) mem_q[r_q][i] <= in_row[i*DW +: DW];
      end
    end
  end

  always_comb begin
    out_col = '0;
    if (out_valid) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (rd_mask[k]) out_col[k*DW +: DW] = mem_q[k][c_q];
      end
    end
  end

endmodule

// File: tb/tb_dct2_transpose_buf.sv
// Directed self-checking bench for dct2_transpose_buf (DW=16, LANES=32).
module tb_dct2_transpose_buf;

  localparam int DW = 16;
  localparam int LANES = 32;
  localparam int W = DW*LANES;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_row;
  logic [1:0]   in_n;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_col;
  logic [1:0]   out_n;

  int errors = 0;
  int checks = 0;

  dct2_transpose_buf #(.DW(DW), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_row(in_row), .in_n(in_n), .out_valid(out_valid), .out_ready(out_ready),
    .out_col(out_col), .out_n(out_n)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // kind 0: 16*r+c, kind 1: signed ramp with -32768 diagonal, kind 2: distinct pattern, kind 3: junk
  function automatic logic [DW-1:0] val(input int kind, input int r, input int c);
    case (kind)
      0:       val = 16'(16*r + c);
      1:       val = (r == c) ? 16'h8000 : 16'(r - c);
      2:       val = 16'(1000*r + 3*c + 5);
      default: val = 16'hA5A5 ^ 16'(r*37 + c);
    endcase
  endfunction

  function automatic logic [W-1:0] make_row(input int r, input int kind);
    logic [W-1:0] v;
    v = '0;
    for (int c = 0; c < LANES; c++) v[c*DW +: DW] = val(kind, r, c);
    return v;
  endfunction

  function automatic logic [W-1:0] exp_col(input int kind, input int c, input int s);
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < s; k++) v[k*DW +: DW] = val(kind, k, c);
    return v;
  endfunction

  task automatic fill(input logic [1:0] n, input int kind, input int gap);
    int s;
    s = 4 << n;
    for (int r = 0; r < s; r++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_row   = make_row(r + 50, 3);
        cyc();
      end
      in_valid = 1'b1;
      in_n     = n;
      in_row   = make_row(r, kind);
      cyc();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_n = 2'b11; out_ready = 1'b1; in_row = make_row(0, 3);
    repeat (3) cyc();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_col !== '0) begin errors++; $display("FAIL reset_out_col got=%h exp=0", out_col); end
    checks++; if (out_n !== 2'b00) begin errors++; $display("FAIL reset_out_n got=%b exp=00", out_n); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      in_valid = 1'b1; in_n = 2'b00; in_row = make_row(r, 0);
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++; $display("FAIL stream_fill_hs row=%0d in_ready=%b out_valid=%b exp=1/0", r, in_ready, out_valid); end
      cyc();
    end
    in_row = make_row(9, 3);  // held valid with junk while draining: must not be written
    for (int c = 0; c < 4; c++) begin
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL stream_drain_hs col=%0d out_valid=%b in_ready=%b exp=1/0", c, out_valid, in_ready); end
      checks++; if (out_col !== exp_col(0, c, 4)) begin
        errors++; $display("FAIL stream_col col=%0d got=%h exp=%h", c, out_col, exp_col(0, c, 4)); end
      checks++; if (out_n !== 2'b00) begin errors++; $display("FAIL stream_out_n got=%b exp=00", out_n); end
      cyc();
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_col !== '0) begin
      errors++; $display("FAIL stream_end out_valid=%b in_ready=%b out_col=%h exp=0/1/0", out_valid, in_ready, out_col); end
  endtask

  task automatic test_signed();
    out_ready = 1'b1;
    fill(2'b11, 1, 0);
    for (int c = 0; c < 32; c++) begin
      checks++; if (out_valid !== 1'b1 || out_col !== exp_col(1, c, 32) || out_n !== 2'b11) begin
        errors++; $display("FAIL signed_col col=%0d v=%b n=%b got=%h exp=%h", c, out_valid, out_n, out_col, exp_col(1, c, 32)); end
      if (c == 5) begin
        checks++; if (out_col[5*DW +: DW] !== 16'h8000) begin
          errors++; $display("FAIL signed_diag got=%h exp=8000", out_col[5*DW +: DW]); end
      end
      cyc();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL signed_end out_valid=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    int done;
    int i;
    out_ready = 1'b1;
    fill(2'b01, 2, 0);
    in_valid = 1'b1; in_row = make_row(3, 3);
    done = 0; i = 0;
    while (done < 8 && i < 100) begin
      out_ready = (i % 3 == 0);
      #1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hs cyc=%0d out_valid=%b in_ready=%b exp=1/0", i, out_valid, in_ready); end
      checks++; if (out_col !== exp_col(2, done, 8)) begin
        errors++; $display("FAIL bp_col idx=%0d got=%h exp=%h", done, out_col, exp_col(2, done, 8)); end
      if (out_ready) done++;
      cyc();
      i++;
    end
    checks++; if (done !== 8) begin errors++; $display("FAIL bp_timeout cols=%0d exp=8", done); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_end out_valid=%b in_ready=%b exp=0/1", out_valid, in_ready); end
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_size_latch();
    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      in_valid = 1'b1; in_n = (r == 0) ? 2'b01 : 2'b11; in_row = make_row(r, 0);
      cyc();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      checks++; if (out_valid !== 1'b1 || out_n !== 2'b01 || out_col !== exp_col(0, c, 8)) begin
        errors++; $display("FAIL latch_col col=%0d v=%b n=%b got=%h exp=%h", c, out_valid, out_n, out_col, exp_col(0, c, 8)); end
      cyc();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latch_end out_valid=%b exp=0", out_valid); end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      in_valid = 1'b1; in_n = 2'b10; in_row = make_row(r, 3);
      cyc();
    end
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL mr_during in_ready=%b out_valid=%b exp=0/0", in_ready, out_valid); end
    cyc();
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL mr_idle cyc=%0d out_valid=%b in_ready=%b exp=0/1", i, out_valid, in_ready); end
      cyc();
    end
    fill(2'b00, 0, 0);
    for (int c = 0; c < 4; c++) begin
      checks++; if (out_valid !== 1'b1 || out_n !== 2'b00 || out_col !== exp_col(0, c, 4)) begin
        errors++; $display("FAIL mr_col col=%0d v=%b n=%b got=%h exp=%h", c, out_valid, out_n, out_col, exp_col(0, c, 4)); end
      cyc();
    end
  endtask

  task automatic test_gaps();
    out_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int g = 0; g < 2; g++) begin
        in_valid = 1'b0; in_row = make_row(r + 20, 3);
        #1;
        checks++; if (out_valid !== 1'b0) begin
          errors++; $display("FAIL gap_early row=%0d out_valid=%b exp=0", r, out_valid); end
        cyc();
      end
      in_valid = 1'b1; in_n = 2'b00; in_row = make_row(r, 2);
      cyc();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++; if (out_valid !== 1'b1 || out_col !== exp_col(2, c, 4)) begin
        errors++; $display("FAIL gap_col col=%0d v=%b got=%h exp=%h", c, out_valid, out_col, exp_col(2, c, 4)); end
      cyc();
    end
  endtask

  task automatic test_back_to_back();
    int cnt;
    out_ready = 1'b1; in_valid = 1'b1; in_n = 2'b00;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      in_row = make_row(i % 4, 0);
      if (out_valid) begin
        checks++; if (out_col !== exp_col(0, cnt % 4, 4)) begin
          errors++; $display("FAIL b2b_col idx=%0d got=%h exp=%h", cnt, out_col, exp_col(0, cnt % 4, 4)); end
        cnt++;
      end
      checks++; if (out_valid !== ((i % 8) >= 4)) begin
        errors++; $display("FAIL b2b_phase cyc=%0d out_valid=%b exp=%b", i, out_valid, ((i % 8) >= 4)); end
      cyc();
    end
    in_valid = 1'b0;
    checks++; if (cnt !== 8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", cnt); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_signed();
    test_backpressure();
    test_size_latch();
    test_mid_reset();
    test_gaps();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dct2_transpose_buf.md
DCT2_TRANSPOSE_BUF -- requirements
Module: dct2_transpose_buf

Interface
REQ-001 The module SHALL have parameter DW, default 16, meaning the signed coefficient width per lane.
REQ-002 The module SHALL have parameter LANES, default 32, meaning the number of lanes per row (maximum transform size).
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  input row present.
REQ-006 in_ready  output  1  block accepts a row this cycle.
REQ-007 in_row  input  LANES*DW  first-pass 1-D DCT output row; lane i occupies bits [i*DW +: DW], two's complement.
REQ-008 in_n  input  2  transform size code: 00=4, 01=8, 10=16, 11=32.
REQ-009 out_valid  output  1  output column present.
REQ-010 out_ready  input  1  downstream accepts the column this cycle.
REQ-011 out_col  output  LANES*DW  transposed column, same lane packing as in_row.
REQ-012 out_n  output  2  size code of the block being drained.

Function
REQ-013 Block size S SHALL equal 4 << n; the row transfer is in_valid && in_ready; the column transfer is out_valid && out_ready.
REQ-014 Storage SHALL be a LANES x LANES array mem[r][c] of DW-bit registers; it is single-buffered.
REQ-015 The FSM SHALL have two states, FILL and DRAIN.
REQ-016 In FILL: in_ready=1 and out_valid=0.
REQ-017 In DRAIN: in_ready=0 and out_valid=1.
REQ-018 At the first row transfer of a block (row count 0), in_n SHALL be latched into the internal size register n_q, and out_n SHALL follow n_q.
REQ-019 in_n SHALL be ignored on rows 1..S-1 of a block.
REQ-020 On a row transfer with row counter r, lanes c < S SHALL be written to mem[r][c]; lanes c >= S SHALL be ignored.
REQ-021 After each row transfer, r SHALL increment; on the transfer with r = S-1, r SHALL clear and the state SHALL become DRAIN on the next cycle.
REQ-022 In DRAIN with column counter c: out_col lane k SHALL equal mem[k][c] for k < S and 0 for k >= S.
REQ-023 out_col SHALL be all-zero whenever out_valid=0.
REQ-024 On a column transfer, c SHALL increment; on the transfer with c = S-1, c SHALL clear and the state SHALL become FILL on the next cycle.
REQ-025 Latency: the first column SHALL be valid on the cycle after the last row transfer.
REQ-026 With in_valid and out_ready held at 1, a block SHALL take exactly 2S cycles; there is no overlap between blocks.
REQ-027 With out_ready=0, out_col and c SHALL hold stable and out_valid SHALL stay 1 (no drop or advance).
REQ-028 With in_valid=0 in FILL, r and mem SHALL hold.
REQ-029 Values SHALL pass through unmodified: no rounding, saturation or sign change; bit-exact.
REQ-030 in_row contents on cycles without a row transfer SHALL NOT alter mem.

Reset
REQ-031 While rst=1: state=FILL, r=0, c=0, n_q=00, in_ready=0, out_valid=0, out_col=0, out_n=00.
REQ-032 On the first cycle after rst deasserts, in_ready SHALL be 1.
REQ-033 mem SHALL NOT be cleared by reset; stale contents are never visible, because out_col is gated to zero by REQ-023 and only rows written in the current block are read.
REQ-034 Reset asserted mid-FILL or mid-DRAIN SHALL abandon the partial block with no column emitted for it.
REQ-035 The first block after a mid-operation reset SHALL behave identically to one issued after power-on reset.

Verification
REQ-036 Case n=00, streaming: rows r=0..3 with lane c = 16*r+c, out_ready=1 -> columns appear on cycles 5..8 (cycle 1 = first row transfer); column c lanes 0..3 = {c, 16+c, 32+c, 48+c}; lanes 4..31 = 0; out_n=00.
REQ-037 Case n=11, signed range: 32 rows with lane c = (r==c) ? -32768 : r-c -> the 32 columns equal the transposed matrix bit-exactly; diagonal lanes = 0x8000.
REQ-038 Case back-pressure: n=01 block, out_ready toggled 1,0,0,1,... -> each column is held while out_ready=0, no column is repeated or skipped, and in_ready stays 0 until the 8th column transfer.
REQ-039 Case size latch: in_n=01 on row 0, then changed to 11 on rows 1..7 -> the block is treated as 8x8, DRAIN is entered after 8 rows, out_n=01.
REQ-040 Case mid-block reset: rst pulsed after row 2 of an n=10 block, then a fresh n=00 block -> no output for the aborted block; the n=00 columns are correct and lanes 4..31 = 0.
REQ-041 Case input gaps: n=00 rows with in_valid bubbles between each row -> DRAIN is entered only after the 4th row transfer, and the columns are correct.
